fir_mac_scheduler: RTL and testbench

//   Time-multiplexed FIR engine controller. Accepts one sample per valid/ready

---
 rtl/fir_mac_scheduler.sv | 161 ++++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - time-multiplexed FIR controller with one shared MAC
//
// Purpose
//   Accepts one sample per handshake into a circular delay line. It then spends
//   TAPS cycles on a single multiplier-accumulator that walks the taps, and
//   presents the saturated, fraction-shifted result until it is consumed.
//   Coefficients are writable at run time while the engine is idle.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     sample handshake, x_in sampled on accept
//   out_valid/out_ready   result handshake, y_out held while out_valid
//   coef_we/addr/data     coefficient write port, honoured only in IDLE
//   coef_err              one-cycle pulse after a rejected coefficient write
//   busy                  engine is not in IDLE

module fir_mac_scheduler #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int SHIFT  = 14,
    localparam int AW    = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y_out,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              coef_err,
    output logic              busy
);

    localparam int PROD_W = DATA_W + COEF_W;
    // AW guard bits cover the sum of TAPS full-scale products.
    localparam int ACC_W  = DATA_W + COEF_W + AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_EXT = TAPS[AW:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                    state;
    logic        [AW-1:0]      wr_ptr;
    logic        [AW-1:0]      k;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  line_q [TAPS];
    logic signed [COEF_W-1:0]  coef_q [TAPS];

    logic                      coef_ok;
    logic        [AW:0]        rd_diff;
    logic        [AW:0]        rd_wrap;
    logic        [AW-1:0]      rd_idx;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   acc_shift;
    logic        [ACC_W-DATA_W:0] acc_upper;
    logic        [DATA_W-1:0]  y_sat;
    logic        [AW-1:0]      ptr_next;

    assign in_ready = (state == IDLE) && !reset;
    assign busy     = (state != IDLE);

    // A write is honoured only while idle and only for an existing tap.
    assign coef_ok = (state == IDLE) && ({1'b0, coef_addr} < TAPS_EXT);

    // Tap k reads the sample that arrived k samples ago: (wr_ptr - k) mod TAPS.
    // Written without relying on power-of-two wrap so any TAPS works.
    assign rd_diff = {1'b0, wr_ptr} - {1'b0, k};
    assign rd_wrap = (wr_ptr < k) ? (rd_diff + TAPS_EXT) : rd_diff;
    assign rd_idx  = rd_wrap[AW-1:0];

    assign prod    = coef_q[k] * line_q[rd_idx];
    assign acc_sum = acc + {{AW{prod[PROD_W-1]}}, prod};

    // Arithmetic shift floors toward -inf; saturate if the bits above the
    // result's sign bit are not a pure sign extension.
    assign acc_shift = acc_sum >>> SHIFT;
    assign acc_upper = acc_shift[ACC_W-1:DATA_W-1];

    always_comb begin
        y_sat = acc_shift[DATA_W-1:0];
        if (!((acc_upper == '0) || (acc_upper == '1))) begin
            if (acc_shift[ACC_W-1]) begin
                y_sat = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                y_sat = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
    end

    assign ptr_next = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            k         <= '0;
            acc       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            coef_err  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                line_q[i] <= '0;
                // Unity gain on tap 0 only: the filter powers up as a passthrough.
                coef_q[i] <= (i == 0) ? COEF_W'(1 << SHIFT) : '0;
            end
        end else begin
            coef_err <= coef_we && !coef_ok;

            // The write lands on the same edge as a simultaneous accept, so the
            // MAC pass for that sample already sees the new coefficient.
            if (coef_we && coef_ok) begin
                coef_q[coef_addr] <= coef_data;
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        line_q[wr_ptr] <= x_in;
                        k              <= '0;
                        acc            <= '0;
                        state          <= MAC;
                    end
                end

                MAC: begin
                    acc <= acc_sum;
                    if (k == LAST_IDX) begin
                        y_out     <= y_sat;
                        out_valid <= 1'b1;
                        wr_ptr    <= ptr_next;
                        state     <= OUT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - directed-vector bench for fir_mac_scheduler

module tb_fir_mac_scheduler;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] x_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] y_out;
    logic               coef_we = 1'b0;
    logic [2:0]         coef_addr = '0;
    logic [15:0]        coef_data = '0;
    logic               coef_err;
    logic               busy;

    int nvec = 0;
    int nmiss = 0;

    fir_mac_scheduler #(
        .DATA_W(16), .COEF_W(16), .TAPS(8), .SHIFT(14)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_out    (y_out),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .coef_err (coef_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nmiss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        coef_we   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 16'(data);
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic accept(input int x);
        @(negedge clk);
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        x_in     = 16'(x);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic send(input string tag, input int x, input int exp);
        int lat;
        accept(x);
        wait_out(lat);
        chk({tag, "_lat"}, lat, 8);
        @(negedge clk);
        chk(tag, y_out, exp);
        consume();
    endtask

    int exp2a [10] = '{12, 25, 37, 50, 62, 75, 87, 100, 100, 100};
    int exp2b [8]  = '{75, 50, 25, 0, -25, -50, -75, -100};
    int exp4b [8]  = '{32767, 32767, 32767, -4, -32768, -32768, -32768, -32768};

    initial begin
        int low_cnt;
        int lat1;
        int y1;

        // 1: reset state, passthrough, handshake timing
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y_out", y_out, 0);
        do_reset();
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_coef_err", coef_err, 0);

        out_ready = 1'b1;
        accept(100);
        low_cnt = 0;
        lat1 = -1;
        y1 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid && lat1 < 0) begin
                lat1 = i;
                y1 = y_out;
            end
            if (in_ready) break;
            low_cnt++;
        end
        out_ready = 1'b0;
        chk("t1_latency", lat1, 8);
        chk("t1_y", y1, 100);
        chk("t1_in_ready_low", low_cnt, 9);

        // 2: moving average with coef 1/8
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, 2048);
        @(negedge clk);
        chk("t2_coef_err", coef_err, 0);
        for (int n = 0; n < 10; n++) send("t2_pos", 100, exp2a[n]);
        for (int n = 0; n < 8; n++) send("t2_neg", -100, exp2b[n]);

        // 3: impulse response walks the coefficient table
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, 1000 * (k + 1));
        send("t3_imp", 16384, 1000);
        for (int n = 1; n < 8; n++) send("t3_tail", 0, 1000 * (n + 1));
        send("t3_flush", 0, 0);

        // 4: saturation at both rails
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, 16384);
        for (int n = 0; n < 8; n++) send("t4_max", 32767, 32767);
        for (int n = 0; n < 8; n++) send("t4_min", -32768, exp4b[n]);

        // 5: backpressure in OUT, ignored in_valid
        do_reset();
        write_coef(1, 16384);
        accept(300);
        wait_out(lat1);
        for (int c = 0; c < 5; c++) begin
            if (c == 1 || c == 2) begin
                in_valid = 1'b1;
                x_in = 16'sd7777;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("t5_hold_y", y_out, 300);
            chk("t5_hold_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("t5_still_valid", out_valid, 1);
        consume();
        send("t5_next", 50, 350);

        // 6: rejected write in MAC, then reset mid-MAC
        do_reset();
        accept(100);
        write_coef(0, 0);
        @(negedge clk);
        chk("t6_coef_err", coef_err, 1);
        @(negedge clk);
        chk("t6_coef_err_clr", coef_err, 0);
        wait_out(lat1);
        @(negedge clk);
        chk("t6_coef_kept", y_out, 100);
        consume();

        accept(200);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_rel_in_ready", in_ready, 1);
        chk("t6_rel_busy", busy, 0);
        send("t6_pass", 100, 100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
